// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants, derived totals and FSM state type.
// Imported by vga_timing_if, vga_lock_sync and vga_timing_gen.
package vga_timing_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;

   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;

   localparam int LOCK_STABLE_D = 1024;
   localparam int X_W_D = 10;
   localparam int Y_W_D = 10;

   function automatic int span_total(
      input int act,
      input int fp,
      input int sync,
      input int bp
   );
      return act + fp + sync + bp;
   endfunction

   localparam int H_TOTAL_D =
      span_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
   localparam int V_TOTAL_D =
      span_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

   typedef enum logic [1:0] {
      WAIT_LOCK,
      STABILIZE,
      RUN
   } state_t;

endpackage

// File: rtl/vga_timing_if.sv
// Raster output bundle: syncs, data-enable, coordinates and strobes.
// master drives (vga_timing_gen), slave consumes; rgb only with VGA_TEST_PATTERN_EN.
interface vga_timing_if
   import vga_timing_pkg::*;
#(
   parameter int X_W = X_W_D,
   parameter int Y_W = Y_W_D
) ();

   logic           hsync;
   logic           vsync;
   logic           de;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic           line_start;
   logic           frame_start;
   logic           running;
`ifdef VGA_TEST_PATTERN_EN
   logic [23:0]    rgb;

   modport master (
      output hsync, vsync, de, x, y,
      output line_start, frame_start, running, rgb
   );
   modport slave (
      input hsync, vsync, de, x, y,
      input line_start, frame_start, running, rgb
   );
`else
   modport master (
      output hsync, vsync, de, x, y,
      output line_start, frame_start, running
   );
   modport slave (
      input hsync, vsync, de, x, y,
      input line_start, frame_start, running
   );
`endif

endinterface

// File: rtl/vga_lock_sync.sv
// PLL-lock synchroniser (2 FF) and consecutive-lock stability counter.
// Ports: clk, rst_n (sync, active-low), pll_locked (async) -> lock_s, lock_ok.
module vga_lock_sync
   import vga_timing_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_D
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_locked,
   output logic lock_s,
   output logic lock_ok
);

   localparam int CW = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_STABLE_CYCLES - 1);

   logic          meta;
   logic [CW-1:0] cnt;

   // cnt holds the number of earlier consecutive cycles with lock_s high,
   // so lock_ok marks the LOCK_STABLE_CYCLES-th stable cycle and then holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta   <= 1'b0;
         lock_s <= 1'b0;
         cnt    <= '0;
      end else begin
         meta   <= pll_locked;
         lock_s <= meta;
         if (!lock_s) begin
            cnt <= '0;
         end else if (!lock_ok) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign lock_ok = lock_s && (cnt == CNT_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator that starts once the pixel PLL lock is stable.
// Ports: clk, rst_n (sync, active-low), pll_locked (async), vo (vga_timing_if.master).
// Option: define VGA_TEST_PATTERN_EN to drive 8 vertical colour bars on vo.rgb.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_D,
   parameter int X_W = X_W_D,
   parameter int Y_W = Y_W_D
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pll_locked,
   vga_timing_if.master vo
);

   localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic HS_ON = (HSYNC_POL != 0);
   localparam logic VS_ON = (VSYNC_POL != 0);

   state_t        state, state_n;
   logic          lock_s, lock_ok;
   logic          run_en;
   logic          de_n, hs_n, vs_n;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;

   vga_lock_sync #(
      .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
   ) u_lock (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked),
      .lock_s    (lock_s),
      .lock_ok   (lock_ok)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= WAIT_LOCK;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         WAIT_LOCK: begin
            if (lock_ok) begin
               state_n = RUN;
            end else if (lock_s) begin
               state_n = STABILIZE;
            end
         end
         STABILIZE: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
            end else if (lock_ok) begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
            end
         end
         default: state_n = WAIT_LOCK;
      endcase
   end

   // Gating with lock_s makes the edge that leaves RUN already idle the
   // raster, so a lock loss never emits one more pixel.
   assign run_en = (state == RUN) && lock_s;

   always_ff @(posedge clk) begin
      if (!rst_n || !run_en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   assign de_n = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_n = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign vs_n = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   logic [2:0]  bar;
   logic [23:0] rgb_n;

   assign bar   = 3'(h_cnt / HW'(BAR_W));
   assign rgb_n = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n || !run_en) begin
         vo.hsync       <= ~HS_ON;
         vo.vsync       <= ~VS_ON;
         vo.de          <= 1'b0;
         vo.x           <= '0;
         vo.y           <= '0;
         vo.line_start  <= 1'b0;
         vo.frame_start <= 1'b0;
         vo.running     <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
         vo.rgb         <= '0;
`endif
      end else begin
         vo.hsync       <= hs_n ? HS_ON : ~HS_ON;
         vo.vsync       <= vs_n ? VS_ON : ~VS_ON;
         vo.de          <= de_n;
         vo.x           <= de_n ? X_W'(h_cnt) : '0;
         vo.y           <= de_n ? Y_W'(v_cnt) : '0;
         vo.line_start  <= de_n && (h_cnt == '0);
         vo.frame_start <= (h_cnt == '0) && (v_cnt == '0);
         vo.running     <= 1'b1;
`ifdef VGA_TEST_PATTERN_EN
         vo.rgb         <= de_n ? rgb_n : '0;
`endif
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised lock/reset stimulus against a cycle-count raster model.
// Small raster geometry keeps several full frames inside a short run.
module tb_vga_timing_gen;

   localparam int L  = 1024;
   localparam int HA = 16;
   localparam int HF = 2;
   localparam int HS = 4;
   localparam int HB = 3;
   localparam int VA = 6;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int LIM = 3000;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        ls;
      logic        fs;
      logic        run;
      logic [23:0] rgb;
   } ov_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pll_locked = 1'b1;

   int vectors = 0;
   int miscompares = 0;
   int printed = 0;
   bit armed = 1'b0;

   bit     m_meta = 1'b0;
   bit     m_ls = 1'b0;
   longint streak = 0;

   always #5 clk = ~clk;

   vga_timing_if #(.X_W(10), .Y_W(10)) vif ();

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(0), .VSYNC_POL(0),
      .LOCK_STABLE_CYCLES(L),
      .X_W(10), .Y_W(10)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked),
      .vo        (vif)
   );

   // streak = consecutive clock edges that saw the synchronised lock high.
   // Pixel 0 of a fresh raster is output on the edge where streak == L+1.
   function automatic ov_t model_out(input longint s);
      ov_t e;
      int  p, h, v, bar;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      if (s >= L + 1) begin
         p = int'((s - (L + 1)) % (HT * VT));
         h = p % HT;
         v = p / HT;
         e.run = 1'b1;
         e.de = (h < HA) && (v < VA);
         e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
         e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
         e.fs = (p == 0);
         if (e.de) begin
            e.x = 10'(h);
            e.y = 10'(v);
            e.ls = (h == 0);
`ifdef VGA_TEST_PATTERN_EN
            bar = h / (HA / 8);
            e.rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`endif
         end
      end
      return e;
   endfunction

   function automatic ov_t actual();
      ov_t a;
      a.hs = vif.hsync;
      a.vs = vif.vsync;
      a.de = vif.de;
      a.x = vif.x;
      a.y = vif.y;
      a.ls = vif.line_start;
      a.fs = vif.frame_start;
      a.run = vif.running;
`ifdef VGA_TEST_PATTERN_EN
      a.rgb = vif.rgb;
`else
      a.rgb = '0;
`endif
      return a;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_meta = 1'b0;
         m_ls = 1'b0;
         streak = 0;
      end else begin
         streak = m_ls ? streak + 1 : 0;
         m_ls = m_meta;
         m_meta = pll_locked;
      end
   end

   always @(negedge clk) begin
      ov_t a, e;
      if (armed) begin
         a = actual();
         e = model_out(streak);
         vectors++;
         if (a !== e) begin
            miscompares++;
            if (printed < 20) begin
               printed++;
               $display("FAIL raster t=%0t got=%h required=%h",
                        $time, a, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input longint act,
                      input longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s got=%0d required=%0d", nm, act, req);
      end
   endtask

   initial begin
      int n, c;
      @(negedge clk);
      armed = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_running", vif.running, 0);
      chk("rst_hsync", vif.hsync, 1);
      chk("rst_vsync", vif.vsync, 1);
      chk("rst_de", vif.de, 0);

      pll_locked = 1'b0;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      pll_locked = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!vif.frame_start && n < LIM);
      chk("lock_to_frame", n, 1027);
      chk("first_x", vif.x, 0);
      chk("first_y", vif.y, 0);
      chk("first_de", vif.de, 1);

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!vif.line_start && n < LIM);
      chk("line_period", n, HT);
      do begin
         @(negedge clk);
         n++;
      end while (!vif.frame_start && n < LIM);
      chk("frame_period", n, HT * VT);

      c = 0;
      for (int i = 0; i < HT; i++) begin
         @(negedge clk);
         if (!vif.hsync) c++;
      end
      chk("hsync_width", c, HS);
      c = 0;
      for (int i = 0; i < HT * VT; i++) begin
         @(negedge clk);
         if (!vif.vsync) c++;
      end
      chk("vsync_width", c, VS * HT);

      pll_locked = 1'b0;
      repeat (10) @(negedge clk);
      pll_locked = 1'b1;
      repeat (500) @(negedge clk);
      chk("stab_running", vif.running, 0);
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!vif.running && n < LIM);
      chk("relock_to_run", n, 1027);

      n = 0;
      while (!(vif.de && vif.y == 10'd3) && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk("reach_y3", n < LIM, 1);
      pll_locked = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (vif.running && n < LIM);
      chk("drop_to_idle", n <= 3, 1);
      chk("drop_de", vif.de, 0);
      chk("drop_hsync", vif.hsync, 1);
      pll_locked = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!vif.frame_start && n < LIM);
      chk("restart_x", vif.x, 0);
      chk("restart_y", vif.y, 0);

`ifdef VGA_TEST_PATTERN_EN
      n = 0;
      while (!(vif.de && vif.y == 10'd2 && vif.x == 10'd0)
             && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk("rgb_bar0", vif.rgb, 24'h000000);
      while (vif.x != 10'd2 && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk("rgb_bar1", vif.rgb, 24'h0000FF);
      while (vif.x != 10'd15 && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk("rgb_bar7", vif.rgb, 24'hFFFFFF);
      while (vif.de && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk("rgb_blank", vif.rgb, 0);
      chk("rgb_wait", n < LIM, 1);
`endif

      for (int it = 0; it < 20; it++) begin
         pll_locked = 1'b1;
         repeat ($urandom_range(100, 1400)) @(negedge clk);
         if ($urandom_range(0, 4) == 0) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
         end
         repeat ($urandom_range(100, 1400)) @(negedge clk);
         pll_locked = 1'b0;
         repeat ($urandom_range(1, 4)) @(negedge clk);
      end

      armed = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
